hazard_control_unit: RTL

- Pipeline hazard controller for the 5-stage RISC-V core, in the ID stage.
- Detects load-use hazards and squashes wrong-path instructions after a taken branch resolved in MEM.
- Freezes the pipeline while data memory is busy.
- Drives `ctrlSelect`, the selector of the ID-stage control-zeroing mux (1 = pass decoded controls, 0 = insert bubble). Also drives PC/IF-ID/ID-EX write enables, flushes and two saturating event counters.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_control_unit_if.sv | 39 +++
 rtl/sat_counter.sv | 37 +++
 rtl/hazard_control_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W_DEFAULT = 5;

  // Selector values for the ID-stage control-zeroing mux.
  localparam logic ctrl_sel_pass   = 1'b1;
  localparam logic ctrl_sel_bubble = 1'b0;

  typedef enum logic [0:0] {
    RUN,
    FLUSH
  } hazard_state_e;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline, slave the controller.
interface hazard_control_unit_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);

  logic                  idex_memRead;
  logic [REG_ADDR_W-1:0] idex_rd;
  logic [REG_ADDR_W-1:0] ifid_rs1;
  logic [REG_ADDR_W-1:0] ifid_rs2;
  logic                  ifid_useRs1;
  logic                  ifid_useRs2;
  logic                  exmem_branchTaken;
  logic                  memBusy;

  logic                  pcWrite;
  logic                  ifidWrite;
  logic                  idexWrite;
  logic                  ctrlSelect;
  logic                  ifidFlush;
  logic                  idexFlush;
  logic [CNT_W-1:0]      stallCount;
  logic [CNT_W-1:0]      flushCount;

  modport master (
    output idex_memRead, idex_rd, ifid_rs1, ifid_rs2, ifid_useRs1, ifid_useRs2,
           exmem_branchTaken, memBusy,
    input  pcWrite, ifidWrite, idexWrite, ctrlSelect, ifidFlush, idexFlush,
           stallCount, flushCount
  );

  modport slave (
    input  idex_memRead, idex_rd, ifid_rs1, ifid_rs2, ifid_useRs1, ifid_useRs2,
           exmem_branchTaken, memBusy,
    output pcWrite, ifidWrite, idexWrite, ctrlSelect, ifidFlush, idexFlush,
           stallCount, flushCount
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a small per-cycle increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned INC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned SumW = CNT_W + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [SumW-1:0]  sum;

  assign sum = {1'b0, count_q} + SumW'(inc);

  // Increment is far smaller than the range, so a carry out means "past max".
  always_comb begin
    count_d = sum[CNT_W-1:0];
    if (sum[CNT_W]) begin
      count_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard controller: load-use stalls, branch squash, memory-busy freeze.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_control_unit_if.slave hzd
);

  localparam int unsigned   RemW     = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [RemW-1:0] RemStart = RemW'(FLUSH_CYCLES - 1);
  localparam hazard_state_e BranchNext = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  hazard_state_e   state_q, state_d;
  logic [RemW-1:0] remain_q, remain_d;

  logic       load_use;
  logic [1:0] stall_inc, flush_inc;
  logic       pc_write, ifid_write, idex_write, ctrl_select, ifid_flush, idex_flush;

  assign load_use = hzd.idex_memRead && (hzd.idex_rd != REG_ADDR_W'(0)) &&
                    ((hzd.ifid_useRs1 && (hzd.idex_rd == hzd.ifid_rs1)) ||
                     (hzd.ifid_useRs2 && (hzd.idex_rd == hzd.ifid_rs2)));

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    stall_inc   = 2'd0;
    flush_inc   = 2'd0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ctrl_select = ctrl_sel_pass;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;

    if (!rst_n) begin
      // Outputs go quiet as soon as reset asserts, not at the next edge.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      ctrl_select = 1'b0;
    end else if (hzd.memBusy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (hzd.exmem_branchTaken) begin
      ctrl_select = ctrl_sel_bubble;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      flush_inc   = 2'd2;
      state_d     = BranchNext;
      remain_d    = (FLUSH_CYCLES > 1) ? RemStart : '0;
    end else if (state_q == FLUSH) begin
      // The ID instruction is on the wrong path, so any load-use match is moot.
      ctrl_select = ctrl_sel_bubble;
      ifid_flush  = 1'b1;
      flush_inc   = 2'd1;
      remain_d    = remain_q - 1'b1;
      if (remain_q == RemW'(1)) begin
        state_d = RUN;
      end
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_select = ctrl_sel_bubble;
      stall_inc   = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  assign hzd.pcWrite    = pc_write;
  assign hzd.ifidWrite  = ifid_write;
  assign hzd.idexWrite  = idex_write;
  assign hzd.ctrlSelect = ctrl_select;
  assign hzd.ifidFlush  = ifid_flush;
  assign hzd.idexFlush  = idex_flush;

  sat_counter #(
    .CNT_W(CNT_W),
    .INC_W(2)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_inc),
    .count(hzd.stallCount)
  );

  sat_counter #(
    .CNT_W(CNT_W),
    .INC_W(2)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (flush_inc),
    .count(hzd.flushCount)
  );

endmodule
